// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer for the miniRISC datapath.
// Define PERF_CNT_EN to build the cycles/instret performance counters; otherwise they read 0.
module instr_sequencer #(
    parameter logic [5:0]  HALT_OP     = 6'h3F,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             regWrite,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             isBranch,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt,
        StErr
    } state_e;

    localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] wait_inc;

    logic mem_req_c, mem_we_c, mem_is_fetch_c, ir_we_c, rf_we_c, pc_we_c;
    logic busy_c, retire;

    // isBranch only steers the datapath's next-PC mux; the sequencer never needs it.
    logic unused_is_branch;
    assign unused_is_branch = isBranch;

    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_is_fetch_c = 1'b0;
        ir_we_c        = 1'b0;
        rf_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        retire         = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req_c      = 1'b1;
                mem_is_fetch_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = StDecode;
                end else if (wait_inc == TimeoutLimit) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StDecode: begin
                state_d = (opcode == HALT_OP) ? StHalt : StExec;
            end
            StExec: begin
                if (memRead || memWrite) begin
                    state_d = StMem;
                end else if (regWrite) begin
                    state_d = StWb;
                end else begin
                    retire = 1'b1;
                end
            end
            StMem: begin
                mem_req_c = 1'b1;
                mem_we_c  = memWrite;
                if (mem_ready) begin
                    if (memRead) state_d = StWb;
                    else         retire  = 1'b1;
                end else if (wait_inc == TimeoutLimit) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StWb: begin
                rf_we_c = regWrite;
                retire  = 1'b1;
            end
            StHalt, StErr: begin
                state_d = state_q;
            end
            default: state_d = StIdle;
        endcase

        // run is only looked at here and in IDLE, so a mid-instruction drop lets it finish.
        if (retire) begin
            pc_we_c = 1'b1;
            state_d = run ? StFetch : StIdle;
        end

        // Every entry into a memory phase starts a fresh wait window.
        if (state_d != state_q) wait_d = '0;
    end

    assign busy_c = (state_q != StIdle) && (state_q != StHalt) && (state_q != StErr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are forced low while reset is held, regardless of the registered state.
    assign mem_req      = rst & mem_req_c;
    assign mem_we       = rst & mem_we_c;
    assign mem_is_fetch = rst & mem_is_fetch_c;
    assign ir_we        = rst & ir_we_c;
    assign rf_we        = rst & rf_we_c;
    assign pc_we        = rst & pc_we_c;
    assign busy         = rst & busy_c;
    assign halted       = rst & (state_q == StHalt);
    assign err          = rst & (state_q == StErr);

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycles_d  = cycles_q + {{(CNT_W-1){1'b0}}, busy_c};
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, pc_we_c};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    assign cycles  = rst ? cycles_q : '0;
    assign instret = rst ? instret_q : '0;
`else
    assign cycles  = '0;
    assign instret = '0;
`endif

    mem_we_needs_req : assert property (@(posedge clk) disable iff (!rst) mem_we |-> mem_req);
    ir_we_is_fetch   : assert property (@(posedge clk) disable iff (!rst)
                                        ir_we |-> (mem_req && mem_is_fetch));
    pc_we_pulse      : assert property (@(posedge clk) disable iff (!rst) pc_we |=> !pc_we);
    ir_we_pulse      : assert property (@(posedge clk) disable iff (!rst) ir_we |=> !ir_we);
    rf_we_pulse      : assert property (@(posedge clk) disable iff (!rst) rf_we |=> !rf_we);
    halt_err_excl    : assert property (@(posedge clk) disable iff (!rst) !(halted && err));

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: each instruction is expanded into its expected
// per-cycle output trace from the phase rules, then compared cycle by cycle.
module tb_instr_sequencer;

    localparam logic [5:0]  HaltOp  = 6'h3F;
    localparam int unsigned Timeout = 15;
    localparam int unsigned CntW    = 32;

    typedef enum int {KAlu, KLoad, KStore, KBranch, KNop} kind_e;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic [5:0]      opcode;
    logic            regWrite, memRead, memWrite, isBranch, mem_ready;
    logic            mem_req, mem_we, mem_is_fetch, ir_we, rf_we, pc_we;
    logic            busy, halted, err;
    logic [CntW-1:0] cycles, instret;

    always #5 clk = ~clk;

    instr_sequencer #(
        .HALT_OP    (HaltOp),
        .MEM_TIMEOUT(Timeout),
        .CNT_W      (CntW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .opcode      (opcode),
        .regWrite    (regWrite),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .isBranch    (isBranch),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_is_fetch(mem_is_fetch),
        .ir_we       (ir_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .busy        (busy),
        .halted      (halted),
        .err         (err),
        .cycles      (cycles),
        .instret     (instret)
    );

    int unsigned     n_cmp = 0;
    int unsigned     n_bad = 0;
    longint unsigned exp_cycles  = 0;
    longint unsigned exp_instret = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit order: req, we, fetch, ir_we, rf_we, pc_we, busy, halted, err.
    function automatic logic [8:0] ov(bit req, bit we, bit fe, bit ir, bit rf, bit pc,
                                      bit bz, bit ht, bit er);
        return {req, we, fe, ir, rf, pc, bz, ht, er};
    endfunction

    task automatic tick(input string tag, input logic [8:0] exp);
        logic [63:0] want_cyc, want_ret;
        @(negedge clk);
        check_eq(tag, {mem_req, mem_we, mem_is_fetch, ir_we, rf_we, pc_we, busy, halted, err},
                 exp);
`ifdef PERF_CNT_EN
        want_cyc = exp_cycles % (64'd1 << CntW);
        want_ret = exp_instret % (64'd1 << CntW);
`else
        want_cyc = 64'd0;
        want_ret = 64'd0;
`endif
        check_eq({tag, ".cycles"}, cycles, want_cyc);
        check_eq({tag, ".instret"}, instret, want_ret);
        if (exp[2]) exp_cycles++;
        if (exp[3]) exp_instret++;
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_ctrl();
        regWrite = 1'($urandom);
        memRead  = 1'($urandom);
        memWrite = 1'($urandom);
        isBranch = 1'($urandom);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst       = 1'b0;
            run       = 1'($urandom);
            opcode    = 6'($urandom);
            mem_ready = 1'($urandom);
            garbage_ctrl();
            @(negedge clk);
            check_eq("reset.outs", {mem_req, mem_we, mem_is_fetch, ir_we, rf_we, pc_we, busy,
                                    halted, err}, 9'd0);
            check_eq("reset.cycles", cycles, 64'd0);
            check_eq("reset.instret", instret, 64'd0);
            @(posedge clk);
            #1;
        end
        rst         = 1'b1;
        exp_cycles  = 0;
        exp_instret = 0;
    endtask

    task automatic idle_then_start(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b0; mem_ready = 1'($urandom); opcode = 6'($urandom); garbage_ctrl();
            tick("idle", ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        run = 1'b1; mem_ready = 1'($urandom); opcode = 6'($urandom); garbage_ctrl();
        tick("idle_go", ov(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic fetch_phase(input int fw);
        for (int i = 0; i < fw; i++) begin
            run = 1'($urandom); mem_ready = 1'b0; opcode = 6'($urandom); garbage_ctrl();
            tick("fetch_wait", ov(1, 0, 1, 0, 0, 0, 1, 0, 0));
        end
        run = 1'($urandom); mem_ready = 1'b1; opcode = 6'($urandom); garbage_ctrl();
        tick("fetch", ov(1, 0, 1, 1, 0, 0, 1, 0, 0));
    endtask

    // Starts with the sequencer in FETCH; next_run is the level presented in the retire cycle.
    task automatic run_instr(input kind_e kind, input int fw, input int mw, input bit next_run);
        bit rw, mr, mwr, br, has_mem, has_wb, is_st;
        logic [5:0] op;
        op  = 6'($urandom_range(0, 62));
        rw  = 0; mr = 0; mwr = 0; br = 0;
        case (kind)
            KAlu:    rw = 1;
            KLoad:   begin mr = 1; rw = ($urandom_range(0, 3) != 0); end
            KStore:  begin mwr = 1; rw = 1'($urandom); end
            KBranch: br = 1;
            default: ;
        endcase
        has_mem = mr || mwr;
        is_st   = mwr;
        has_wb  = (kind == KAlu) || (kind == KLoad);

        fetch_phase(fw);

        run = 1'($urandom); mem_ready = 1'($urandom); opcode = op; garbage_ctrl();
        tick("decode", ov(0, 0, 0, 0, 0, 0, 1, 0, 0));

        regWrite = rw; memRead = mr; memWrite = mwr; isBranch = br;
        mem_ready = 1'($urandom);
        if (!has_mem && !has_wb) begin
            run = next_run;
            tick("exec_retire", ov(0, 0, 0, 0, 0, 1, 1, 0, 0));
        end else begin
            run = 1'($urandom);
            tick("exec", ov(0, 0, 0, 0, 0, 0, 1, 0, 0));
        end

        if (has_mem) begin
            for (int i = 0; i < mw; i++) begin
                run = 1'($urandom); mem_ready = 1'b0;
                tick("mem_wait", ov(1, mwr, 0, 0, 0, 0, 1, 0, 0));
            end
            run = is_st ? next_run : 1'($urandom);
            mem_ready = 1'b1;
            tick("mem", ov(1, mwr, 0, 0, 0, is_st, 1, 0, 0));
        end

        if (has_wb) begin
            run = next_run; mem_ready = 1'($urandom);
            tick("wb", ov(0, 0, 0, 0, rw, 1, 1, 0, 0));
        end
    endtask

    initial begin
        bit    in_idle;
        bit    nr;
        kind_e k;

        do_reset(2);

        // Zero-wait ALU op, then stop.
        idle_then_start(0);
        run_instr(KAlu, 0, 0, 1'b0);
        // Load with two MEM wait cycles, run dropped at retire.
        idle_then_start(1);
        run_instr(KLoad, 0, 2, 1'b0);
        // Store, then back-to-back branch; wait windows at the limit minus one.
        idle_then_start(0);
        run_instr(KStore, 0, 0, 1'b1);
        run_instr(KBranch, Timeout - 1, 0, 1'b1);
        run_instr(KLoad, 0, Timeout - 1, 1'b0);

        in_idle = 1'b1;
        for (int n = 0; n < 250; n++) begin
            if (in_idle) idle_then_start($urandom_range(0, 3));
            k  = kind_e'($urandom_range(0, 4));
            nr = ($urandom_range(0, 3) != 0);
            run_instr(k, $urandom_range(0, 4) == 0 ? $urandom_range(0, Timeout - 1) : 0,
                      $urandom_range(0, 4) == 0 ? $urandom_range(0, Timeout - 1) : 0, nr);
            in_idle = !nr;
        end

        // Reset asserted mid-instruction forces outputs low.
        if (in_idle) idle_then_start(0);
        fetch_phase(1);
        do_reset(1);

        // HALT opcode.
        idle_then_start(0);
        fetch_phase(2);
        run = 1'b1; mem_ready = 1'($urandom); opcode = HaltOp; garbage_ctrl();
        tick("decode_halt", ov(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            run = 1'($urandom); mem_ready = 1'($urandom); opcode = 6'($urandom); garbage_ctrl();
            tick("halt", ov(0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        do_reset(1);
        idle_then_start(0);
        run_instr(KAlu, 0, 0, 1'b0);

        // Fetch timeout.
        idle_then_start(0);
        for (int i = 0; i < int'(Timeout); i++) begin
            run = 1'b1; mem_ready = 1'b0; opcode = 6'($urandom); garbage_ctrl();
            tick("fetch_to", ov(1, 0, 1, 0, 0, 0, 1, 0, 0));
        end
        for (int i = 0; i < 4; i++) begin
            run = 1'($urandom); mem_ready = 1'($urandom); opcode = 6'($urandom); garbage_ctrl();
            tick("err_fetch", ov(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        do_reset(1);
        run = 1'b0; mem_ready = 1'b0;
        tick("after_err_reset", ov(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Data-access timeout on a store.
        idle_then_start(0);
        fetch_phase(0);
        run = 1'b1; mem_ready = 1'b0; opcode = 6'h01; garbage_ctrl();
        tick("decode", ov(0, 0, 0, 0, 0, 0, 1, 0, 0));
        regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b1; isBranch = 1'b0;
        tick("exec", ov(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < int'(Timeout); i++) begin
            mem_ready = 1'b0;
            tick("mem_to", ov(1, 1, 0, 0, 0, 0, 1, 0, 0));
        end
        for (int i = 0; i < 3; i++) begin
            run = 1'($urandom); mem_ready = 1'($urandom);
            tick("err_mem", ov(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        do_reset(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
